// File: rtl/axil_read_slave.sv
// axil_read_slave: AXI4-Lite read-only slave over four local registers.
// Ports: clk/rstn; AR channel s_araddr, s_arvalid, s_arready;
//   R channel s_rdata, s_rresp, s_rvalid, s_rready;
//   local write port reg_we, reg_idx, reg_wdata.
// Build macro AXIL_RD_SLVERR_EN: addresses with any bit above bit 3
//   set return SLVERR (s_rresp=2'b10) with zero data.
module axil_read_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic              reg_we,
    input  logic [1:0]        reg_idx,
    input  logic [DATA_W-1:0] reg_wdata
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [1:0]        cap_idx;
    logic              cap_err;
    logic              ar_err;
    logic              ar_hs;
    logic [DATA_W-1:0] regs [4];

    // Only bits [3:2] select a register; the rest feed the range check
    // when it is built in.
    logic addr_unused;
    assign addr_unused = ^s_araddr;

`ifdef AXIL_RD_SLVERR_EN
    assign ar_err = |(s_araddr >> 4);
`else
    assign ar_err = 1'b0;
`endif

    assign ar_hs = s_arvalid && s_arready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[reg_idx] <= reg_wdata;
        end
    end

    // RESP has two phases: the first edge in RESP loads the data and
    // raises s_rvalid (a same-edge local write is not yet visible), then
    // the beat is held until s_rready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_err   <= 1'b0;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    s_arready <= 1'b1;
                    if (ar_hs) begin
                        cap_idx   <= s_araddr[3:2];
                        cap_err   <= ar_err;
                        s_arready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (!s_rvalid) begin
                        s_rvalid <= 1'b1;
                        s_rdata  <= cap_err ? '0 : regs[cap_idx];
                        s_rresp  <= cap_err ? 2'b10 : 2'b00;
                    end else if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axil_read_slave.md
AXIL_READ_SLAVE -- requirements
Module: axil_read_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the read address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the read data and register width in bits.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between address acceptance and data presentation (legal range 0-15).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rstn, input, 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port s_araddr, input, ADDR_W, meaning the read byte address.
REQ-007 The block SHALL have port s_arvalid, input, 1, meaning the master's address-valid signal.
REQ-008 The block SHALL have port s_arready, output, 1, meaning the slave's address-ready signal.
REQ-009 The block SHALL have port s_rdata, output, DATA_W, meaning the read data.
REQ-010 The block SHALL have port s_rresp, output, 2, meaning the read response (2'b00 OKAY, 2'b10 SLVERR).
REQ-011 The block SHALL have port s_rvalid, output, 1, meaning the read-data-valid signal.
REQ-012 The block SHALL have port s_rready, input, 1, meaning the master's read-data-ready signal.
REQ-013 The block SHALL have port reg_we, input, 1, meaning the local register write strobe.
REQ-014 The block SHALL have port reg_idx, input, 2, meaning the local register write index.
REQ-015 The block SHALL have port reg_wdata, input, DATA_W, meaning the local register write data.

Function
REQ-016 The block SHALL hold 4 registers of DATA_W bits; on reg_we at a rising edge, register[reg_idx] <= reg_wdata, regardless of read-channel state.
REQ-017 The block SHALL implement FSM states IDLE, WAIT and RESP; s_arready SHALL be 1 only in IDLE; at most one read SHALL be outstanding.
REQ-018 In IDLE, an AR handshake (s_arvalid && s_arready at edge E) SHALL capture s_araddr, drop s_arready, and enter WAIT with the counter set to WAIT_CYCLES, or enter RESP directly when WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter equals 1.
REQ-020 s_rvalid SHALL rise at edge E+WAIT_CYCLES+1, loading s_rdata from register[captured_addr[3:2]]; captured_addr[1:0] SHALL be ignored.
REQ-021 If a reg_we to the selected register coincides with the data-load edge, s_rdata SHALL carry the pre-write value.
REQ-022 In RESP, s_rvalid, s_rdata and s_rresp SHALL stay stable until s_rready; on an R handshake, s_rvalid SHALL fall and s_arready SHALL rise at the same edge (FSM returns to IDLE).
REQ-023 s_arvalid asserted outside IDLE SHALL be ignored (not captured).
REQ-024 s_rdata SHALL hold its last value when s_rvalid=0; s_rresp SHALL be 2'b00 unless REQ-029 applies.

Reset
REQ-025 On rstn=0 the block SHALL immediately (asynchronously) force state IDLE, counter 0, all registers 0, s_arready=0, s_rvalid=0, s_rdata=0 and s_rresp=2'b00.
REQ-026 s_arready SHALL rise at the first rising edge after rstn deasserts.
REQ-027 Reset mid-transaction SHALL abort the transaction with no response issued.

Configuration
REQ-028 Macro AXIL_RD_SLVERR_EN SHALL select address-range checking.
REQ-029 With AXIL_RD_SLVERR_EN defined, a captured address with any bit above bit 3 set SHALL return s_rresp=2'b10 and s_rdata=0 with the same timing as REQ-020.
REQ-030 Without AXIL_RD_SLVERR_EN, all addresses SHALL alias on bits [3:2] and s_rresp SHALL always be 2'b00.

Verification
REQ-031 Reset release, then reg_we idx=1 data 0xA5A5_0001, read addr 0x04 with WAIT_CYCLES=2 and s_rready=1 -> s_rvalid rises 3 edges after the AR handshake, s_rdata=0xA5A5_0001, s_rresp=00.
REQ-032 Read addr 0x08 with s_rready held 0 for 5 cycles -> s_rvalid and s_rdata stay stable, s_arready stays 0, and a second s_arvalid during this time is ignored; the handshake completes on the cycle s_rready rises.
REQ-033 reg_we idx=2 0x1111 at the data-load edge of a read of 0x08 (register previously 0x2222) -> s_rdata=0x2222, and the next read returns 0x1111.
REQ-034 With WAIT_CYCLES=0 and back-to-back reads 0x00 then 0x0C -> s_rvalid at E+1 each time, and s_arready is 1 the cycle after each R handshake.
REQ-035 With AXIL_RD_SLVERR_EN, read 0x40 -> s_rresp=10, s_rdata=0; without the macro, read 0x44 -> s_rresp=00 with register1 data.
REQ-036 rstn pulsed low during WAIT -> s_rvalid never asserts, registers read back 0, and s_arready=1 one edge after release.
